// File: rtl/uart_alu_if.sv
// uart_alu_if: assembles {A, B, opcode} from the UART receiver, drives the
// combinational ALU, captures its result one cycle later and hands it to
// the UART transmitter with a one-cycle start pulse.
module uart_alu_if #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_data_a,
    output logic [NB_DATA-1:0] o_alu_data_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_err,
    output logic               o_overrun
);

    // A zero timeout still needs a one-bit counter so the design elaborates.
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rx_done_p1;
    logic             tx_done_p1;
    logic             rx_accept;
    logic             tx_accept;
    logic             op_ok;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt;

    logic load_a;
    logic load_b;
    logic load_op;
    logic err_set;
    logic start_set;
    logic busy_clr;
    logic ovr_set;

    // Opcode must have zero padding above the ALU field and name a supported op.
    function automatic logic opcode_valid(input logic [NB_DATA-1:0] b);
        logic [NB_OP-1:0] op;
        op = b[NB_OP-1:0];
        if (b[NB_DATA-1:NB_OP] != '0)
            return 1'b0;
        return (op == NB_OP'('h20)) || (op == NB_OP'('h22)) ||
               (op == NB_OP'('h24)) || (op == NB_OP'('h25)) ||
               (op == NB_OP'('h26)) || (op == NB_OP'('h03)) ||
               (op == NB_OP'('h02)) || (op == NB_OP'('h27));
    endfunction

    // Rising-edge strobes: a level held high counts only once.
    assign rx_accept = i_rx_done & ~rx_done_p1;
    assign tx_accept = i_tx_done & ~tx_done_p1;
    assign op_ok     = opcode_valid(i_rx_data);

    // An accept on the expiry edge wins, so the timeout is masked by it.
    assign timeout_hit = (TIMEOUT_CYC != 0) && !rx_accept &&
                         ((state == WAIT_B) || (state == WAIT_OP)) &&
                         (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= WAIT_A;
        else
            state <= state_nxt;
    end

    // Next-state logic; any unexpected encoding falls back to WAIT_A.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_A:  if (rx_accept) state_nxt = WAIT_B;
            WAIT_B: begin
                if (rx_accept)        state_nxt = WAIT_OP;
                else if (timeout_hit) state_nxt = WAIT_A;
            end
            WAIT_OP: begin
                if (rx_accept)        state_nxt = op_ok ? EXEC : WAIT_A;
                else if (timeout_hit) state_nxt = WAIT_A;
            end
            EXEC:    state_nxt = WAIT_TX;
            WAIT_TX: if (tx_accept) state_nxt = WAIT_A;
            default: state_nxt = WAIT_A;
        endcase
    end

    // Per-state control strobes feeding the registered outputs.
    always_comb begin
        load_a    = (state == WAIT_A)  && rx_accept;
        load_b    = (state == WAIT_B)  && rx_accept;
        load_op   = (state == WAIT_OP) && rx_accept && op_ok;
        err_set   = ((state == WAIT_OP) && rx_accept && !op_ok) || timeout_hit;
        start_set = (state == EXEC);
        busy_clr  = (state == WAIT_TX) && tx_accept;
        ovr_set   = ((state == EXEC) || (state == WAIT_TX)) && rx_accept;
    end

    // Edge-detect history, inter-byte counter and all registered outputs.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_done_p1   <= 1'b0;
            tx_done_p1   <= 1'b0;
            cnt          <= '0;
            o_alu_data_a <= '0;
            o_alu_data_b <= '0;
            o_alu_op     <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_busy       <= 1'b0;
            o_err        <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            rx_done_p1 <= i_rx_done;
            tx_done_p1 <= i_tx_done;

            if (rx_accept || (state_nxt == WAIT_A) ||
                !((state == WAIT_B) || (state == WAIT_OP)))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (load_a)    o_alu_data_a <= i_rx_data;
            if (load_b)    o_alu_data_b <= i_rx_data;
            if (load_op)   o_alu_op     <= i_rx_data[NB_OP-1:0];
            if (start_set) o_tx_data    <= i_alu_result;

            o_tx_start <= start_set;
            o_err      <= err_set;

            if (load_op)       o_busy <= 1'b1;
            else if (busy_clr) o_busy <= 1'b0;

            if (ovr_set) o_overrun <= 1'b1;
        end
    end

endmodule

// File: doc/uart_alu_if.md
# uart_alu_if

Command-assembly and result-return stage placed directly downstream of the UART receiver and upstream of the UART transmitter. Collects three received bytes (operand A, operand B, opcode), drives them onto a combinational ALU, captures the result one cycle later and hands it to the transmitter with a start pulse. Partial frames are discarded on an inter-byte timeout. Invalid opcodes are rejected without transmission.

## Interface
- NB_DATA, 8, byte and ALU operand/result width
- NB_OP, 6, ALU opcode width
- TIMEOUT_CYC, 1000000, max clk cycles between bytes of one frame; 0 disables the timeout
- clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_rx_data  in  NB_DATA  received byte, valid while i_rx_done is high
- i_rx_done  in  1  byte-received strobe from the receiver
- i_alu_result  in  NB_DATA  combinational ALU output
- i_tx_done  in  1  transmit-complete strobe from the transmitter
- o_alu_data_a  out  NB_DATA  operand A
- o_alu_data_b  out  NB_DATA  operand B
- o_alu_op  out  NB_OP  opcode
- o_tx_data  out  NB_DATA  byte to transmit
- o_tx_start  out  1  one-cycle transmit request
- o_busy  out  1  high from opcode acceptance until transmit done
- o_err  out  1  one-cycle pulse on invalid opcode or timeout
- o_overrun  out  1  sticky; a byte arrived while busy

## Operation
- Byte accept: rising edge of i_rx_done. A registered copy of i_rx_done is kept, and a byte is accepted when i_rx_done=1 and the previous value is 0. i_rx_data is sampled on that edge. A level held high counts once.
- States are WAIT_A, WAIT_B, WAIT_OP, EXEC and WAIT_TX.
- WAIT_A: on accept, load o_alu_data_a and go to WAIT_B.
- WAIT_B: on accept, load o_alu_data_b and go to WAIT_OP.
- WAIT_OP: on accept, check the opcode.
  - Valid: upper NB_DATA-NB_OP bits are 0 and the low bits are one of 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x03 SRA, 0x02 SRL, 0x27 NOR.
  - If valid: load o_alu_op, set o_busy, go to EXEC.
  - If invalid: o_alu_op is unchanged, pulse o_err, go to WAIT_A.
- EXEC: o_tx_data <= i_alu_result, o_tx_start <= 1, go to WAIT_TX.
- WAIT_TX: on a rising edge of i_tx_done (same edge-detect rule as i_rx_done), clear o_busy and go to WAIT_A.
- Timeout counter:
  - Cleared on every accepted byte and on entry to WAIT_A.
  - Counts only in WAIT_B and WAIT_OP.
  - When it reaches TIMEOUT_CYC-1 with no accept, go to WAIT_A and pulse o_err. Operand registers keep their values.
  - Width is clog2(TIMEOUT_CYC+1).
- Bytes accepted in EXEC or WAIT_TX are dropped and set o_overrun. o_overrun clears only on reset.
- Unreachable or illegal state encodings go to WAIT_A.

## Timing
- Reset values:
  - All outputs are 0.
  - State is WAIT_A.
  - Counter and edge-detect registers are 0.
- Operand and opcode registers update on the accept edge and are visible the following cycle. They hold until overwritten.
- Opcode accepted at edge T:
  - EXEC during cycle T..T+1.
  - The result is sampled at edge T+1, so the ALU has one full cycle from the o_alu_op update.
  - o_tx_start is high for exactly one cycle, T+1..T+2, and o_tx_data is stable from T+1.
- o_busy rises at T. It falls on the edge that detects i_tx_done.
- o_err is high for exactly one cycle, starting at the edge after the error condition.
- Simultaneous events:
  - Accept and timeout expiry on the same edge: the accept wins, and the counter clears.
  - i_tx_done rising in the same cycle as an i_rx_done rise: tx_done completes the transaction, and the byte counts as overrun.
- Asynchronous reset mid-frame or mid-transmit: outputs go to 0 immediately. No o_tx_start is issued after reset until a full new frame arrives.

## Test plan
- Frame 0x05, 0x03, 0x20 with an ADD model:
  - o_alu_data_a=0x05, o_alu_data_b=0x03, o_alu_op=0x20.
  - One o_tx_start pulse one cycle after the opcode accept, with o_tx_data=0x08.
  - o_busy=1 until an i_tx_done pulse, then 0.
- Frame 0x01, 0x02, 0x3F: o_err pulses once, no o_tx_start, o_alu_op is unchanged. A following frame 0x0F, 0x01, 0x22 transmits 0x0E.
- TIMEOUT_CYC=100: send A=0x11, idle 100 cycles, then o_err pulses once. Next bytes 0x02, 0x03, 0x20 yield o_tx_data=0x05, proving 0x02 is taken as A.
- A byte arriving during WAIT_TX: o_overrun=1 and stays 1; the transmitted byte is unchanged. The next full frame is processed normally.
- i_rx_done held high for 5 cycles per byte: each counts once, and 0x07, 0x01, 0x20 transmits 0x08.
- Assert i_rst_n=0 after bytes A and B: all outputs read 0. After release, a fresh three-byte frame is required before o_tx_start.
